motor_poll_scheduler: RTL

MOTOR_POLL_SCHEDULER -- requirements
Module: motor_poll_scheduler

---
 rtl/motor_poll_scheduler.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_poll_scheduler.sv
// motor_poll_scheduler
//
// Round-robin poll scheduler for motors that share one UART link. A phase
// accumulator turns update_frequency_Hz into poll-round ticks. On each tick
// the scheduler sends one frame per enabled motor, lowest index first. The
// frame is a config frame when the host has a config pending for that motor,
// otherwise a setpoint/status frame. After each frame it waits for the motor's
// reply, or for a timeout, and reports the outcome on the stat_* pulse.
//
// Ports
//   clk                  clock, rising edge
//   reset                asynchronous, active-high reset
//   update_frequency_Hz  poll rounds per second (0 halts scheduling)
//   motor_enable         bit m set: motor m takes part in the round
//   cfg_pending          bit m set: motor m needs a config frame
//   tx_req/tx_motor/tx_type  frame request to the UART framer (type 1 = config)
//   tx_ack               framer accepted the request
//   tx_done              last byte of the frame shifted out (one-cycle pulse)
//   rx_valid/rx_motor/rx_crc_ok  decoded reply strobe, source, CRC result
//   cfg_clear            one-cycle pulse clearing the host's pending-config bit
//   stat_valid/stat_motor/stat_ok  per-slot result pulse
//   round_done           one-cycle pulse at the end of every round
//   overrun              sticky: a tick arrived while a round was in progress
//   overrun_clr          clears overrun (a simultaneous set wins)

module motor_poll_scheduler #(
  parameter int unsigned NUMBER_OF_MOTORS = 8,
  parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 5000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
  input  logic [NUMBER_OF_MOTORS-1:0] cfg_pending,
  output logic                        tx_req,
  output logic [7:0]                  tx_motor,
  output logic                        tx_type,
  input  logic                        tx_ack,
  input  logic                        tx_done,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_motor,
  input  logic                        rx_crc_ok,
  output logic [NUMBER_OF_MOTORS-1:0] cfg_clear,
  output logic                        stat_valid,
  output logic [7:0]                  stat_motor,
  output logic                        stat_ok,
  output logic                        round_done,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  // The reply counter runs 0..TIMEOUT_CYCLES-1. The slot times out in the
  // TIMEOUT_CYCLES-th cycle spent in WAIT_RX.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0] ClkFreq = 33'(CLOCK_FREQ_HZ);
  localparam logic [NUMBER_OF_MOTORS-1:0] SlotOne = NUMBER_OF_MOTORS'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitTx,
    StWaitRx,
    StNext
  } state_e;

  // Tick generator
  logic [31:0] r_phase;
  logic [31:0] w_phase_next;
  logic [32:0] w_phase_sum;
  logic        w_tick;

  // Scheduler state
  state_e          r_state;
  state_e          w_state_next;
  logic [7:0]      r_motor;
  logic [7:0]      w_motor_next;
  logic            r_type;
  logic            w_type_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_round_done;
  logic            w_round_done_next;
  logic            r_overrun;
  logic            w_overrun_next;

  // Slot selection
  logic       w_first_found;
  logic       w_first_cfg;
  logic [7:0] w_first_idx;
  logic       w_next_found;
  logic       w_next_cfg;
  logic [7:0] w_next_idx;

  logic w_reply_match;
  logic w_timeout;

  // Phase accumulator. The sum is one bit wider so a large frequency cannot
  // wrap the phase. At or above the clock rate every cycle ticks and the phase
  // is left alone.
  always_comb begin
    w_phase_sum  = {1'b0, r_phase} + {1'b0, update_frequency_Hz};
    w_phase_next = r_phase;
    w_tick       = 1'b0;
    if ({1'b0, update_frequency_Hz} >= ClkFreq) begin
      w_tick = 1'b1;
    end else if (w_phase_sum >= ClkFreq) begin
      w_tick       = 1'b1;
      w_phase_next = 32'(w_phase_sum - ClkFreq);
    end else begin
      w_phase_next = w_phase_sum[31:0];
    end
  end

  // Lowest-index enabled motor, used to start a round.
  always_comb begin
    w_first_found = 1'b0;
    w_first_cfg   = 1'b0;
    w_first_idx   = '0;
    for (int i = int'(NUMBER_OF_MOTORS) - 1; i >= 0; i--) begin
      if (motor_enable[i]) begin
        w_first_found = 1'b1;
        w_first_cfg   = cfg_pending[i];
        w_first_idx   = 8'(i);
      end
    end
  end

  // Next enabled motor above the current one. The enable mask is sampled
  // afresh at each decision.
  always_comb begin
    w_next_found = 1'b0;
    w_next_cfg   = 1'b0;
    w_next_idx   = '0;
    for (int i = int'(NUMBER_OF_MOTORS) - 1; i >= 0; i--) begin
      if (motor_enable[i] && (i > int'(r_motor))) begin
        w_next_found = 1'b1;
        w_next_cfg   = cfg_pending[i];
        w_next_idx   = 8'(i);
      end
    end
  end

  assign w_reply_match = rx_valid && (rx_motor == r_motor);
  assign w_timeout     = (r_cnt == CntLast);

  // Next-state and pulse outputs
  always_comb begin
    w_state_next      = r_state;
    w_motor_next      = r_motor;
    w_type_next       = r_type;
    w_cnt_next        = r_cnt;
    w_round_done_next = 1'b0;
    cfg_clear         = '0;
    stat_valid        = 1'b0;
    stat_ok           = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_tick) begin
          if (w_first_found) begin
            w_motor_next = w_first_idx;
            w_type_next  = w_first_cfg;
            w_state_next = StSend;
          end else begin
            w_round_done_next = 1'b1;
          end
        end
      end

      StSend: begin
        if (tx_ack) begin
          w_state_next = StWaitTx;
          if (r_type) begin
            cfg_clear = SlotOne << r_motor;
          end
        end
      end

      StWaitTx: begin
        if (tx_done) begin
          w_cnt_next   = '0;
          w_state_next = StWaitRx;
        end
      end

      StWaitRx: begin
        // A matching reply takes priority over a timeout in the same cycle.
        if (w_reply_match) begin
          stat_valid   = 1'b1;
          stat_ok      = rx_crc_ok;
          w_state_next = StNext;
        end else if (w_timeout) begin
          stat_valid   = 1'b1;
          w_state_next = StNext;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      StNext: begin
        if (w_next_found) begin
          w_motor_next = w_next_idx;
          w_type_next  = w_next_cfg;
          w_state_next = StSend;
        end else begin
          w_round_done_next = 1'b1;
          w_state_next      = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Ticks outside IDLE are dropped. Recording one wins over a same-cycle clear.
  always_comb begin
    w_overrun_next = r_overrun;
    if (w_tick && (r_state != StIdle)) begin
      w_overrun_next = 1'b1;
    end else if (overrun_clr) begin
      w_overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= '0;
      r_state      <= StIdle;
      r_motor      <= '0;
      r_type       <= 1'b0;
      r_cnt        <= '0;
      r_round_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_phase      <= w_phase_next;
      r_state      <= w_state_next;
      r_motor      <= w_motor_next;
      r_type       <= w_type_next;
      r_cnt        <= w_cnt_next;
      r_round_done <= w_round_done_next;
      r_overrun    <= w_overrun_next;
    end
  end

  assign tx_req     = (r_state == StSend);
  assign tx_motor   = r_motor;
  assign tx_type    = r_type;
  assign stat_motor = r_motor;
  assign round_done = r_round_done;
  assign overrun    = r_overrun;

endmodule
